// File: rtl/ssd_pkg.sv
// Shared types and constants for the multiplexed seven-segment display driver.
// The bundle struct is sized for the largest supported display (MAX_DIGITS
// digits, MAX_PWM_BITS brightness bits); narrower instances zero-extend into it.
package ssd_pkg;

  localparam int MAX_DIGITS   = 16;
  localparam int MAX_PWM_BITS = 8;

  // Active-low "off" levels for the cathode and decimal-point outputs
  localparam logic [6:0] CAT_OFF = 7'h7F;
  localparam logic       DP_OFF  = 1'b1;

  // One display update: everything that must change atomically at a frame edge
  typedef struct packed {
    logic [4*MAX_DIGITS-1:0] data;        // hex nibbles, digit i at [4i+3:4i]
    logic [MAX_DIGITS-1:0]   dp;          // decimal point, 1 = lit
    logic [MAX_DIGITS-1:0]   en;          // digit enable, 1 = shown
    logic [MAX_DIGITS-1:0]   blink;       // digit follows the blink phase
    logic [MAX_PWM_BITS:0]   brightness;  // duty level, 0 = dark
  } ssd_bundle_t;

endpackage

// File: rtl/bto7s.sv
// Hex nibble to seven-segment decoder. Output is active-high, s_out[0] = a
// through s_out[6] = g; 0xA..0xF render as A, b, C, d, E, F.
module bto7s (
  input  logic [3:0] x_in,
  output logic [6:0] s_out
);

  // Pure lookup of the segment pattern for each nibble value
  always_comb begin
    s_out = 7'h00;
    case (x_in)
      4'h0: s_out = 7'h3F;
      4'h1: s_out = 7'h06;
      4'h2: s_out = 7'h5B;
      4'h3: s_out = 7'h4F;
      4'h4: s_out = 7'h66;
      4'h5: s_out = 7'h6D;
      4'h6: s_out = 7'h7D;
      4'h7: s_out = 7'h07;
      4'h8: s_out = 7'h7F;
      4'h9: s_out = 7'h6F;
      4'hA: s_out = 7'h77;
      4'hB: s_out = 7'h7C;
      4'hC: s_out = 7'h39;
      4'hD: s_out = 7'h5E;
      4'hE: s_out = 7'h79;
      4'hF: s_out = 7'h71;
      default: s_out = 7'h00;
    endcase
  end

endmodule

// File: rtl/multi_digit_display_driver.sv
// Time-multiplexed driver for up to 16 seven-segment digits with per-digit
// enable, decimal point and blink, global PWM brightness, and a double-buffered
// input bundle that only reaches the display at a frame boundary.
// Optional feature macro: SSD_BLANK_LEADING_ZEROS_EN (suppress leading zeros).
// cat_out[0] = segment a ... cat_out[6] = segment g, all outputs active-low.
module multi_digit_display_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,       // 1..MAX_DIGITS
  parameter int COUNT_TO     = 100000,  // clocks per digit slot, minus one
  parameter int PWM_BITS     = 4,       // 1..MAX_PWM_BITS
  parameter int BLINK_FRAMES = 64       // frames per blink half-period
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   enable_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic [PWM_BITS:0]       brightness_in,
  input  logic                    valid_in,
  output logic                    ready_out,
  output logic [6:0]              cat_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_out
);

  localparam int CNT_W = (COUNT_TO > 0) ? $clog2(COUNT_TO + 1) : 1;
  localparam int FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int BR_W  = MAX_PWM_BITS + 1;
  localparam logic [3:0] LAST_IDX = 4'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]    slot_cnt;
  logic [3:0]          digit_idx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [FC_W-1:0]     frame_cnt;
  logic                blink_phase;

  ssd_bundle_t bundle_in;
  ssd_bundle_t pending_q;
  ssd_bundle_t active_q;
  logic        pending_full;

  logic        slot_last;
  logic        frame_last;
  logic        accept;
  logic [3:0]  digit_nibble;
  logic [6:0]  seg_on;
  logic        lit_base;
  logic        digit_lit;

  // Handshake: a bundle transfers on any clock where valid_in and ready_out are
  // both high. ready_out is high exactly while the pending buffer is empty (and
  // never during reset); the sender may change the bundle freely while ready_out
  // is low, and only the value present on the accepting clock is captured.
  assign ready_out  = ~pending_full & ~rst_in;
  assign accept     = valid_in & ready_out;

  assign slot_last  = (slot_cnt == CNT_W'(COUNT_TO));
  assign frame_last = slot_last && (digit_idx == LAST_IDX);
  assign frame_out  = frame_last & ~rst_in;

  // Widen the port bundle into the package-sized struct
  always_comb begin
    bundle_in            = '0;
    bundle_in.data       = (4*MAX_DIGITS)'(data_in);
    bundle_in.dp         = MAX_DIGITS'(dp_in);
    bundle_in.en         = MAX_DIGITS'(enable_in);
    bundle_in.blink      = MAX_DIGITS'(blink_in);
    bundle_in.brightness = BR_W'(brightness_in);
  end

  // Slot/digit scan, free-running PWM counter and blink phase
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      pwm_cnt     <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b1;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (slot_last) begin
        slot_cnt  <= '0;
        digit_idx <= (digit_idx == LAST_IDX) ? 4'd0 : digit_idx + 4'd1;
      end else begin
        slot_cnt <= slot_cnt + CNT_W'(1);
      end
      if (frame_last) begin
        if (frame_cnt == FC_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FC_W'(1);
        end
      end
    end
  end

  // Double buffer: accept into pending, promote to active only at a frame edge.
  // An accept can only happen while pending is empty and a promotion only while
  // it is full, so the two never fight; a bundle accepted on the boundary clock
  // simply waits a whole frame in pending.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pending_q    <= '0;
      pending_full <= 1'b0;
      active_q     <= '0;
    end else begin
      if (frame_last && pending_full) begin
        active_q     <= pending_q;
        pending_full <= 1'b0;
      end
      if (accept) begin
        pending_q    <= bundle_in;
        pending_full <= 1'b1;
      end
    end
  end

  assign digit_nibble = active_q.data[{digit_idx, 2'b00} +: 4];

  bto7s u_bto7s (
    .x_in  (digit_nibble),
    .s_out (seg_on)
  );

  assign lit_base = active_q.en[digit_idx]
                 && (BR_W'(pwm_cnt) < active_q.brightness)
                 && (!active_q.blink[digit_idx] || blink_phase);

`ifdef SSD_BLANK_LEADING_ZEROS_EN
  logic [MAX_DIGITS-1:0] blank;

  // A zero digit is blank when no enabled nonzero digit sits at or above it;
  // digit 0 always shows so a value of zero still reads "0"
  always_comb begin
    logic seen;
    seen  = 1'b0;
    blank = '0;
    for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
      if (active_q.en[i] && (active_q.data[4*i +: 4] != 4'h0)) seen = 1'b1;
      blank[i] = (i != 0) && !seen && (active_q.data[4*i +: 4] == 4'h0);
    end
  end

  assign digit_lit = lit_base & ~blank[digit_idx];
`else
  assign digit_lit = lit_base;
`endif

  // Registered pin drivers: one clock behind the scan/PWM state
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      an_out  <= '1;
      cat_out <= CAT_OFF;
      dp_out  <= DP_OFF;
    end else if (digit_lit) begin
      an_out  <= ~(NUM_DIGITS'(1) << digit_idx);
      cat_out <= ~seg_on;
      dp_out  <= ~active_q.dp[digit_idx];
    end else begin
      an_out  <= '1;
      cat_out <= CAT_OFF;
      dp_out  <= DP_OFF;
    end
  end

endmodule

// File: tb/tb_multi_digit_display_driver.sv
// Directed bench for multi_digit_display_driver: 4 digits, 4-clock slots
// (16-clock frames), 4-bit PWM, 2-frame blink half-period.
// Build with SSD_BLANK_LEADING_ZEROS_EN defined to exercise leading-zero blanking.
module tb_multi_digit_display_driver;

  localparam int ND = 4;
  localparam int CT = 3;
  localparam int PB = 4;
  localparam int BF = 2;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [15:0]   data_in;
  logic [3:0]    dp_in;
  logic [3:0]    enable_in;
  logic [3:0]    blink_in;
  logic [4:0]    brightness_in;
  logic          valid_in;
  logic          ready_out;
  logic [6:0]    cat_out;
  logic          dp_out;
  logic [3:0]    an_out;
  logic          frame_out;

  int n_checks = 0;
  int n_pass   = 0;
  int frames_seen = 0;
  logic [11:0] exp_q[$];

  multi_digit_display_driver #(
    .NUM_DIGITS   (ND),
    .COUNT_TO     (CT),
    .PWM_BITS     (PB),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .data_in       (data_in),
    .dp_in         (dp_in),
    .enable_in     (enable_in),
    .blink_in      (blink_in),
    .brightness_in (brightness_in),
    .valid_in      (valid_in),
    .ready_out     (ready_out),
    .cat_out       (cat_out),
    .dp_out        (dp_out),
    .an_out        (an_out),
    .frame_out     (frame_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // Frame boundaries completed since reset release
  always @(posedge clk_in) begin
    if (rst_in) frames_seen <= 0;
    else if (frame_out) frames_seen <= frames_seen + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Active-low cathode pattern, bit0 = a .. bit6 = g
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send_bundle(input logic [15:0] d, input logic [3:0] dpv,
                             input logic [3:0] en, input logic [3:0] bl,
                             input logic [4:0] br);
    int n = 0;
    data_in = d; dp_in = dpv; enable_in = en; blink_in = bl; brightness_in = br;
    valid_in = 1'b1;
    while (!ready_out && n < 64) begin step(); n++; end
    check("send_ready_wait", 32'(n < 64), 32'd1);
    step();
    valid_in = 1'b0;
  endtask

  // Returns just after the clock edge that ends the current frame
  task automatic wait_boundary();
    int n = 0;
    while (frame_out !== 1'b1 && n < 64) begin step(); n++; end
    check("frame_wait", 32'(n < 64), 32'd1);
    step();
  endtask

  // Call right after a frame edge; walks one full frame and ends after the next
  task automatic scan_frame(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] shown);
    logic [11:0] got;
    logic [11:0] exp;
    logic [3:0]  an_e;
    for (int k = 0; k < 16; k++) begin
      int di = k / 4;
      an_e = ~(4'b0001 << di);
      if (shown[di]) exp_q.push_back({an_e, ~dpv[di], seg7(d[4*di +: 4])});
      else           exp_q.push_back({4'hF, 1'b1, 7'h7F});
    end
    for (int k = 0; k < 16; k++) begin
      step();
      got = {an_out, dp_out, cat_out};
      exp = exp_q.pop_front();
      check($sformatf("scan_%0h_k%0d", d, k), 32'(got), 32'(exp));
    end
  endtask

  task automatic count_lit(input int n, output int lit);
    lit = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (an_out != 4'hF) lit++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int lit;
    logic saw_ready;
    logic phase;

    data_in = '0; dp_in = '0; enable_in = '0; blink_in = '0;
    brightness_in = '0; valid_in = 1'b0; rst_in = 1'b0;

    #2 rst_in = 1'b1;
    #1;
    check("rst_an",    32'(an_out),    32'hF);
    check("rst_cat",   32'(cat_out),   32'h7F);
    check("rst_dp",    32'(dp_out),    32'd1);
    check("rst_ready", 32'(ready_out), 32'd0);
    check("rst_frame", 32'(frame_out), 32'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_in = 1'b0;
    #1;
    check("ready_after_rst", 32'(ready_out), 32'd1);
    step();

    // Digit scan with 0x1234, dp on digit 1
    send_bundle(16'h1234, 4'b0010, 4'hF, 4'h0, 5'd16);
    check("pending_full",     32'(ready_out), 32'd0);
    check("first_frame_dark", 32'(an_out),    32'hF);
    wait_boundary();
    check("pending_cleared",  32'(ready_out), 32'd1);
    check("dark_at_boundary", 32'(an_out),    32'hF);
    scan_frame(16'h1234, 4'b0010, 4'hF);

    // Second bundle while the first is pending: no tearing, ready held low
    repeat (5) step();
    data_in = 16'h5678; valid_in = 1'b1;
    check("ready_mid_frame", 32'(ready_out), 32'd1);
    step();
    check("accept_b2", 32'(ready_out), 32'd0);
    data_in = 16'h9ABC;
    n = 0; saw_ready = 1'b0;
    while (frame_out !== 1'b1 && n < 64) begin
      step();
      if (ready_out) saw_ready = 1'b1;
      n++;
    end
    check("b2_frame_wait",   32'(n < 64),  32'd1);
    check("ready_held_low",  32'(saw_ready), 32'd0);
    check("ready_at_frame",  32'(ready_out), 32'd0);
    check("old_at_frame",    32'({an_out, cat_out}), 32'({4'b0111, 7'h79}));
    step();
    check("ready_reopens",   32'(ready_out), 32'd1);
    check("old_after_edge",  32'(cat_out),   32'h79);
    step();
    valid_in = 1'b0;
    check("accept_b3",       32'(ready_out), 32'd0);
    check("b2_shown",        32'({an_out, cat_out}), 32'({4'b1110, 7'h00}));
    wait_boundary();
    step();
    check("b3_shown",        32'({an_out, cat_out}), 32'({4'b1110, 7'h46}));

    // PWM duty: lit clocks per 16-clock frame
    send_bundle(16'h1234, 4'h0, 4'hF, 4'h0, 5'd4);
    wait_boundary();
    count_lit(16, lit);
    check("pwm_4_of_16", 32'(lit), 32'd4);
    send_bundle(16'h1234, 4'h0, 4'hF, 4'h0, 5'd8);
    wait_boundary();
    count_lit(16, lit);
    check("pwm_8_of_16", 32'(lit), 32'd8);
    send_bundle(16'h1234, 4'h0, 4'hF, 4'h0, 5'd0);
    wait_boundary();
    count_lit(16, lit);
    check("pwm_dark", 32'(lit), 32'd0);

    // Blink digit 0: phase starts at 1 and flips every 2 frames
    send_bundle(16'h1234, 4'h0, 4'hF, 4'b0001, 5'd16);
    wait_boundary();
    for (int f = 0; f < 4; f++) begin
      phase = 1'b1 ^ 1'((frames_seen / 2) % 2);
      step();
      check($sformatf("blink_d0_f%0d", frames_seen), 32'(an_out), phase ? 32'hE : 32'hF);
      repeat (4) step();
      check($sformatf("blink_d1_f%0d", frames_seen), 32'(an_out), 32'hD);
      wait_boundary();
    end

    // Value 0x0050: leading zeros blanked only in the blanking build
    send_bundle(16'h0050, 4'h0, 4'hF, 4'h0, 5'd16);
    wait_boundary();
`ifdef SSD_BLANK_LEADING_ZEROS_EN
    scan_frame(16'h0050, 4'h0, 4'b0011);
`else
    scan_frame(16'h0050, 4'h0, 4'b1111);
`endif

    // Asynchronous reset mid-slot with a bundle pending
    send_bundle(16'h1111, 4'h0, 4'hF, 4'h0, 5'd16);
    check("pending_before_rst", 32'(ready_out), 32'd0);
    check("lit_before_rst",     32'(an_out),    32'hE);
    #2 rst_in = 1'b1;
    #1;
    check("async_an",    32'(an_out),    32'hF);
    check("async_cat",   32'(cat_out),   32'h7F);
    check("async_dp",    32'(dp_out),    32'd1);
    check("async_ready", 32'(ready_out), 32'd0);
    check("async_frame", 32'(frame_out), 32'd0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in) rst_in = 1'b0;
    #1;
    check("pending_discarded", 32'(ready_out), 32'd1);
    count_lit(40, lit);
    check("dark_after_rst", 32'(lit), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
